// File: rtl/csa_cpa_resolve.sv
// csa_cpa_resolve
//   Collapses the redundant sum/carry pair from the 3:2 carry-save array into
//   one binary word, r = g + 2*f. The addition runs D bits per cycle. The carry
//   between digits passes only through a flop, so the critical path is a single
//   D-bit adder. The block holds at most one operation at a time.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous, active-low reset
//   in_valid   : g_in/f_in valid
//   in_ready   : block can accept an input (IDLE)
//   g_in [W]   : CSA sum vector, weight 2^i
//   f_in [W]   : CSA carry vector, weight 2^(i+1)
//   out_valid  : r_out holds a completed result (DONE)
//   out_ready  : consumer accepts r_out
//   r_out[W+2] : g + 2f, meaningful only while out_valid=1
//   busy       : high in ADD and DONE
module csa_cpa_resolve #(
    parameter int W = 75,
    parameter int D = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] g_in,
    input  logic [W-1:0] f_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+1:0] r_out,
    output logic         busy
);

    // ceil((W+1)/D) digits cover the W+1-bit shifted carry vector
    localparam int NDIG = (W + D) / D;
    localparam int PW   = NDIG * D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [PW-1:0] a_sh;
    logic [PW-1:0] b_sh;
    // Bits [PW-1:0] collect the digits, and bit PW takes the final carry
    logic [PW:0]   res;

    logic          accept;
    logic [D:0]    sum;
    logic [PW-1:0] res_shift;

    assign accept = (state == IDLE) && in_valid;

    // One digit per cycle. The new digit enters the result register at the top,
    // so after NDIG cycles digit 0 has moved down to bit 0.
    // NOTE: every variable written here gets a value on every pass, so no latch can be inferred.
    always_comb begin
        sum       = {1'b0, a_sh[D-1:0]} + {1'b0, b_sh[D-1:0]} + {{D{1'b0}}, carry};
        res_shift = PW'({sum[D-1:0], res[PW-1:0]} >> D);
    end

    // Control state. It is cleared on reset, so an operation that reset aborts leaves no trace.
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            res   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= ADD;
                        cnt   <= '0;
                        carry <= 1'b0;
                    end
                end
                ADD: begin
                    res[PW-1:0] <= res_shift;
                    carry       <= sum[D];
                    cnt         <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        res[PW] <= sum[D];
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand shift registers. They are always loaded before use, so they need no reset.
    // NOTE: wide datapath registers are left without reset on purpose, and only control state is reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= PW'(g_in);
            b_sh <= PW'({f_in, 1'b0});
        end else if (state == ADD) begin
            a_sh <= a_sh >> D;
            b_sh <= b_sh >> D;
        end
    end

    // The true result is below 3*2^W, so the padded bits above W+1 are always zero.
    generate
        if (PW > W + 1) begin : g_trim
            logic unused_pad;
            assign unused_pad = ^res[PW:W+2];
            assign r_out      = res[W+1:0];
        end else begin : g_exact
            assign r_out = res;
        end
    endgenerate

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_csa_cpa_resolve.sv
module tb_csa_cpa_resolve;

    localparam int W    = 75;
    localparam int D    = 25;
    localparam int NDIG = (W + D) / D;

    typedef logic [W+1:0] res_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] g_in;
    logic [W-1:0] f_in;
    logic         out_valid;
    logic         out_ready;
    logic [W+1:0] r_out;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    csa_cpa_resolve #(.W(W), .D(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_in      (g_in),
        .f_in      (f_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_out     (r_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge, where outputs are sampled and inputs driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    // Reference: plain arithmetic on the operands
    function automatic res_t model(input logic [W-1:0] g, input logic [W-1:0] f);
        return res_t'(g) + 2 * res_t'(f);
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 4 * NDIG) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, in_ready, 1);
    endtask

    // Called just after the accept edge. It waits for the result, checks the latency and value,
    // optionally holds out_ready low, then releases the result.
    task automatic collect(input string tag, input res_t exp, input int hold);
        int lat = 0;
        while (!out_valid && lat < 4 * NDIG) begin
            in_valid = 1'($urandom_range(0, 1));
            g_in     = rand_w();
            f_in     = rand_w();
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, NDIG);
        check({tag, "_r"}, r_out, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            g_in     = rand_w();
            f_in     = rand_w();
            tick();
            check({tag, "_hold"}, {in_ready, out_valid, r_out}, {1'b0, 1'b1, exp});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_release"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] g, input logic [W-1:0] f,
                          input int gap, input int hold);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (gap) tick();
        wait_ready(tag);
        g_in     = g;
        f_in     = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        collect(tag, model(g, f), hold);
    endtask

    initial begin
        logic [W-1:0] g1, f1, g2, f2;
        int           n_out;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        g_in      = '0;
        f_in      = '0;
        tick();
        tick();
        check("reset_state", {in_ready, out_valid, busy, r_out}, {1'b1, 1'b0, 1'b0, res_t'(0)});
        rst_n = 1'b1;

        // Reset during the second ADD cycle aborts the operation
        g_in     = W'(5);
        f_in     = W'(3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midop_reset", {in_ready, out_valid, busy, r_out}, {1'b1, 1'b0, 1'b0, res_t'(0)});
        out_ready = 1'b1;
        n_out     = 0;
        repeat (3 * NDIG) begin
            tick();
            if (out_valid) n_out++;
        end
        out_ready = 1'b0;
        check("midop_no_output", n_out, 0);

        // Directed cases
        run_op("zero", '0, '0, 0, 0);
        run_op("basic", W'(5), W'(3), 0, 1);
        run_op("full_chain", {W{1'b1}}, {W{1'b1}}, 1, 0);
        check("full_chain_const", model({W{1'b1}}, {W{1'b1}}), {2'b10, {(W-2){1'b1}}, 2'b01});
        run_op("digit_bound", W'((76'd1 << 24) - 76'd1), W'(1), 0, 0);
        g1 = '0;
        g1[W-1] = 1'b1;
        run_op("top_bit", W'(1), g1, 0, 2);

        // Backpressure: out_ready held low for 6 cycles while new data is offered
        g1 = rand_w();
        f1 = rand_w();
        g2 = rand_w();
        f2 = rand_w();
        wait_ready("bp");
        g_in     = g1;
        f_in     = f1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_out = 0;
        while (!out_valid && n_out < 4 * NDIG) begin
            tick();
            n_out++;
        end
        check("bp_latency", n_out, NDIG);
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            g_in     = g2;
            f_in     = f2;
            tick();
            check("bp_hold", {in_ready, out_valid, r_out}, {1'b0, 1'b1, model(g1, f1)});
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle", {in_ready, out_valid}, 2'b10);
        tick();
        in_valid = 1'b0;
        collect("bp_new", model(g2, f2), 0);

        // Random regression
        for (int i = 0; i < 2000; i++) begin
            run_op("rand", rand_w(), rand_w(), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
